fp_norm_round: RTL and testbench

- Back end of the FP add/sub datapath.
- Consumes the signed two's-complement mantissa sum and the common (larger) biased exponent from the mantissa adder/subtractor stage.
- Produces an IEEE-754 packed sign/exponent/fraction with round-to-nearest-even.
- Normalisation is iterative, one bit per cycle, with valid/ready handshakes on both sides.

---
 rtl/fp_norm_round.sv | 217 +++++++++++++++++++++
 tb/tb_fp_norm_round.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_round.sv
// fp_norm_round: normalise and round-to-nearest-even back end of the FP add/sub path.
// Takes the signed mantissa sum plus common biased exponent and returns an IEEE-754
// sign/exponent/fraction with overflow, inexact, zero and subnormal flags.
// Optional macro FP_NORM_LZC_EN: the normalise step uses a leading-zero count and
// finishes in one cycle instead of shifting one bit per cycle.
module fp_norm_round #(
  parameter int unsigned MANTISSA_WIDTH = 23,
  parameter int unsigned EXPONENT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [MANTISSA_WIDTH+5:0]   in_sum,
  input  logic [EXPONENT_WIDTH-1:0]   in_exp,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_sign,
  output logic [EXPONENT_WIDTH-1:0]   out_exp,
  output logic [MANTISSA_WIDTH-1:0]   out_mant,
  output logic                        out_ovf,
  output logic                        out_inexact,
  output logic                        out_zero,
  output logic                        out_denorm
);

  localparam int unsigned MW   = MANTISSA_WIDTH;
  localparam int unsigned EW   = EXPONENT_WIDTH;
  localparam int unsigned SW   = MW + 6;  // signed sum width
  localparam int unsigned MAGW = MW + 5;  // magnitude width (overflow..sticky)
  localparam int unsigned XW   = EW + 1;  // internal exponent, one guard bit
  localparam int unsigned RW   = MW + 2;  // rounded significand incl. carry out

  localparam logic [XW-1:0] EXP_INF = XW'((1 << EW) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  state_t              r_state;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_sign;
  logic [MAGW-1:0]     r_mag;
  logic [XW-1:0]       r_exp;
  logic                r_out_sign;
  logic [EW-1:0]       r_out_exp;
  logic [MW-1:0]       r_out_mant;
  logic                r_out_ovf;
  logic                r_out_inexact;
  logic                r_out_zero;
  logic                r_out_denorm;

  logic [MAGW-1:0]     w_mag_in;
  logic [XW-1:0]       w_exp_in;
  logic                w_round_up;
  logic [RW-1:0]       w_rsum;
  logic [MW:0]         w_rmant;
  logic [XW-1:0]       w_rexp;
  logic                w_hidden;
  logic                w_ovf;

  // Magnitude of the two's-complement sum; low bits of the negation only need low input bits
  assign w_mag_in = in_sum[SW-1] ? MAGW'(~in_sum[MAGW-1:0] + MAGW'(1)) : in_sum[MAGW-1:0];
  assign w_exp_in = (in_exp == '0) ? XW'(1) : {1'b0, in_exp};

  // Round-to-nearest-even on the normalised magnitude, with carry-out renormalisation
  always_comb begin
    w_round_up = r_mag[2] & (r_mag[1] | r_mag[0] | r_mag[3]);
    w_rsum     = RW'(r_mag[MAGW-2:3]) + RW'(w_round_up);
    if (w_rsum[RW-1]) begin
      w_rmant = w_rsum[RW-1:1];
      w_rexp  = r_exp + XW'(1);
    end else begin
      w_rmant = w_rsum[MW:0];
      w_rexp  = r_exp;
    end
    w_hidden = w_rmant[MW];
    w_ovf    = (w_rexp >= EXP_INF);
  end

`ifdef FP_NORM_LZC_EN
  logic [XW-1:0]   w_lzc;
  logic [XW-1:0]   w_shamt;
  logic            w_found;
  logic [MAGW-1:0] w_mag_sh;

  // Leading-zero count below the hidden position, clamped so the exponent stops at 1
  always_comb begin
    w_lzc   = '0;
    w_found = 1'b0;
    for (int i = MAGW - 2; i >= 0; i--) begin
      if (!w_found) begin
        if (r_mag[i]) begin
          w_found = 1'b1;
        end else begin
          w_lzc = w_lzc + XW'(1);
        end
      end
    end
    w_shamt = (w_lzc < (r_exp - XW'(1))) ? w_lzc : (r_exp - XW'(1));
    if (r_mag == '0) begin
      w_shamt = '0;
    end
    w_mag_sh = r_mag << w_shamt;
  end
`endif

  // Control FSM and datapath registers; outputs are loaded in ROUND and held through DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_in_ready    <= 1'b1;
      r_out_valid   <= 1'b0;
      r_sign        <= 1'b0;
      r_mag         <= '0;
      r_exp         <= '0;
      r_out_sign    <= 1'b0;
      r_out_exp     <= '0;
      r_out_mant    <= '0;
      r_out_ovf     <= 1'b0;
      r_out_inexact <= 1'b0;
      r_out_zero    <= 1'b0;
      r_out_denorm  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign     <= in_sum[SW-1];
            r_mag      <= w_mag_in;
            r_exp      <= w_exp_in;
            r_in_ready <= 1'b0;
            r_state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          // Adder carry: shift right once, folding the lost R bit into sticky
          if (r_mag[MAGW-1]) begin
            r_mag <= {1'b0, r_mag[MAGW-1:2], r_mag[1] | r_mag[0]};
            r_exp <= r_exp + XW'(1);
          end
          r_state <= S_NORM;
        end
        S_NORM: begin
`ifdef FP_NORM_LZC_EN
          r_mag   <= w_mag_sh;
          r_exp   <= r_exp - w_shamt;
          r_state <= S_ROUND;
`else
          if ((r_mag == '0) || r_mag[MAGW-2] || (r_exp == XW'(1))) begin
            r_state <= S_ROUND;
          end else begin
            r_mag <= r_mag << 1;
            r_exp <= r_exp - XW'(1);
          end
`endif
        end
        S_ROUND: begin
          if (r_mag == '0) begin
            r_out_sign    <= 1'b0;
            r_out_exp     <= '0;
            r_out_mant    <= '0;
            r_out_ovf     <= 1'b0;
            r_out_inexact <= 1'b0;
            r_out_zero    <= 1'b1;
            r_out_denorm  <= 1'b0;
          end else if (w_ovf) begin
            r_out_sign    <= r_sign;
            r_out_exp     <= '1;
            r_out_mant    <= '0;
            r_out_ovf     <= 1'b1;
            r_out_inexact <= 1'b1;
            r_out_zero    <= 1'b0;
            r_out_denorm  <= 1'b0;
          end else begin
            r_out_sign    <= r_sign;
            r_out_exp     <= w_hidden ? w_rexp[EW-1:0] : '0;
            r_out_mant    <= w_rmant[MW-1:0];
            r_out_ovf     <= 1'b0;
            r_out_inexact <= |r_mag[2:0];
            r_out_zero    <= 1'b0;
            r_out_denorm  <= ~w_hidden;
          end
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_sign    = r_out_sign;
  assign out_exp     = r_out_exp;
  assign out_mant    = r_out_mant;
  assign out_ovf     = r_out_ovf;
  assign out_inexact = r_out_inexact;
  assign out_zero    = r_out_zero;
  assign out_denorm  = r_out_denorm;

endmodule

// File: tb/tb_fp_norm_round.sv
// tb_fp_norm_round: scoreboard bench for fp_norm_round with an arithmetic reference model.
module tb_fp_norm_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [28:0] in_sum;
  logic [7:0]  in_exp;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [22:0] out_mant;
  logic        out_ovf;
  logic        out_inexact;
  logic        out_zero;
  logic        out_denorm;

  fp_norm_round #(.MANTISSA_WIDTH(23), .EXPONENT_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sum      (in_sum),
    .in_exp      (in_exp),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sign    (out_sign),
    .out_exp     (out_exp),
    .out_mant    (out_mant),
    .out_ovf     (out_ovf),
    .out_inexact (out_inexact),
    .out_zero    (out_zero),
    .out_denorm  (out_denorm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
    logic        ovf;
    logic        inexact;
    logic        zero;
    logic        denorm;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   have_cur = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   ready_mode = 2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: exact value, normalise against the exponent floor, nearest-even rounding
  function automatic exp_t model(input logic [28:0] s, input logic [7:0] ex);
    exp_t   r;
    longint v;
    longint a;
    longint m;
    int     e;
    int     k;
    bit     up;
    v = longint'({35'd0, s});
    a = s[28] ? ((longint'(1) << 29) - v) : v;
    e = (ex == 8'd0) ? 1 : int'(ex);
    if (a >= (longint'(1) << 27)) begin
      a = (a >> 1) | (a & 1);
      e++;
    end
    k = 0;
    while (a != 0 && a < (longint'(1) << 26) && e > 1) begin
      a = a * 2;
      e--;
      k++;
    end
    m  = a >> 3;
    up = a[2] && ((a[1:0] != 2'b00) || m[0]);
    m  = m + (up ? 1 : 0);
    if (m >= (longint'(1) << 24)) begin
      m = m >> 1;
      e++;
    end
    r.sign = 1'b0; r.exp = 8'd0; r.mant = 23'd0;
    r.ovf = 1'b0; r.inexact = 1'b0; r.zero = 1'b0; r.denorm = 1'b0;
    r.acc = 0;
`ifdef FP_NORM_LZC_EN
    r.lat = 3;
`else
    r.lat = 3 + k;
`endif
    if (a == 0) begin
      r.zero = 1'b1;
    end else if (e >= 255) begin
      r.sign = s[28]; r.exp = 8'hFF; r.ovf = 1'b1; r.inexact = 1'b1;
    end else begin
      r.sign    = s[28];
      r.exp     = (m >= (longint'(1) << 23)) ? 8'(e) : 8'd0;
      r.mant    = 23'(m);
      r.inexact = (a[2:0] != 3'b000);
      r.denorm  = (m < (longint'(1) << 23));
    end
    return r;
  endfunction

  task automatic send(input logic [28:0] s, input logic [7:0] ex, input bit track);
    exp_t e;
    int   w;
    e = model(s, ex);
    @(posedge clk);
    #1;
    in_sum   = s;
    in_exp   = ex;
    in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready got 0, required 1 within 300 cycles");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.acc = cyc;
    if (track) q.push_back(e);
    in_valid = 1'b0;
  endtask

  // Downstream ready: random, held low, or held high
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'($urandom_range(0, 1));
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pop on each new result, re-check while held, check in_ready low
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        have_cur = 1'b0;
      end else if (out_valid) begin
        if (!have_cur) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got out_valid 1 with empty scoreboard, required 0");
          end else begin
            cur = q.pop_front();
            have_cur = 1'b1;
            chk("latency", 64'(cyc - cur.acc), 64'(cur.lat));
          end
        end
        if (have_cur) begin
          chk("sign", out_sign, cur.sign);
          chk("exp", out_exp, cur.exp);
          chk("mant", out_mant, cur.mant);
          chk("ovf", out_ovf, cur.ovf);
          chk("inexact", out_inexact, cur.inexact);
          chk("zero", out_zero, cur.zero);
          chk("denorm", out_denorm, cur.denorm);
        end
        chk("in_ready_busy", in_ready, 1'b0);
        if (out_ready) have_cur = 1'b0;
      end
    end
  end

  initial begin
    int          w;
    int          sh;
    logic [27:0] mg;
    logic [28:0] s;
    logic [7:0]  ex;
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_exp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1'b1);
    chk("idle_out_valid", out_valid, 1'b0);
    chk("idle_sign", out_sign, 1'b0);
    chk("idle_exp", out_exp, 8'd0);
    chk("idle_mant", out_mant, 23'd0);
    chk("idle_flags", {out_ovf, out_inexact, out_zero, out_denorm}, 4'd0);

    // Directed corner cases
    send(29'h0800_0000, 8'd127, 1'b1);
    send(29'h0800_0000, 8'd254, 1'b1);
    send(29'h1C00_0000, 8'd10,  1'b1);
    send(29'h0000_0000, 8'd50,  1'b1);
    send(29'h0000_0008, 8'd127, 1'b1);
    send(29'h07FF_FFFC, 8'd127, 1'b1);
    send(29'h0400_0004, 8'd127, 1'b1);
    send(29'h0400_000C, 8'd127, 1'b1);
    send(29'h0010_0000, 8'd3,   1'b1);
    send(29'h0000_0001, 8'd0,   1'b1);

    // Backpressure: hold out_ready low across a completed result
    send(29'h0400_000C, 8'd127, 1'b1);
    ready_mode = 1;
    w = 0;
    @(negedge clk);
    while (!out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    repeat (5) begin
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1'b1);
    end
    ready_mode = 2;

    // Abort: reset while normalising must discard the result
    send(29'h0000_0008, 8'd127, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_out_valid", out_valid, 1'b0);
    repeat (35) begin
      @(negedge clk);
      chk("abort_no_valid", out_valid, 1'b0);
    end

    // Random traffic across shift depths, signs and exponent ranges
    ready_mode = 0;
    repeat (200) begin
      sh = $urandom_range(0, 28);
      mg = 28'($urandom) & 28'((64'd1 << sh) - 64'd1);
      s  = {1'b0, mg};
      if ($urandom_range(0, 1) == 1) s = ~s + 29'd1;
      case ($urandom_range(0, 2))
        0:       ex = 8'($urandom_range(0, 6));
        1:       ex = 8'($urandom_range(0, 254));
        default: ex = 8'($urandom_range(248, 254));
      endcase
      send(s, ex, 1'b1);
    end

    ready_mode = 2;
    w = 0;
    while ((q.size() != 0 || have_cur || out_valid) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (q.size() != 0 || out_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d results pending, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
